// File: rtl/mult_issue_queue.sv
// Operand FIFO feeding a sequential multiplier, one op in flight at a time.
// Define MULT_ISSUE_TIMEOUT_EN to add a 15-cycle WAIT watchdog with err_o.
module mult_issue_queue #(
    parameter int W     = 4,
    parameter int DEPTH = 4
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     in_valid_i,
    input  logic [W-1:0]             in_x_i,
    input  logic [W-1:0]             in_y_i,
    output logic                     in_ready_o,
    output logic [W-1:0]             mul_x_o,
    output logic [W-1:0]             mul_y_o,
    output logic                     mul_start_o,
    input  logic [W-1:0]             mul_product_i,
    input  logic                     mul_ready_i,
    output logic                     res_valid_o,
    output logic [W-1:0]             res_data_o,
    input  logic                     res_ready_i,
    output logic                     err_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_t;

    state_t state_q, state_d;

    logic [W-1:0]  mem_x [DEPTH];
    logic [W-1:0]  mem_y [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LW-1:0] level_q;

    logic          full, empty, push, pop;
    logic          issue_go, timeout;

    logic          mul_start_q;
    logic [W-1:0]  mul_x_q, mul_y_q;
    logic          res_valid_q;
    logic [W-1:0]  res_data_q;

    assign full     = (level_q == LW'(DEPTH));
    assign empty    = (level_q == '0);
    assign push     = in_valid_i && !full;
    assign pop      = (state_q == ISSUE);
    assign issue_go = (state_q == IDLE) && !empty && !res_valid_q;

    assign in_ready_o  = !full;
    assign level_o     = level_q;
    assign mul_start_o = mul_start_q;
    assign mul_x_o     = mul_x_q;
    assign mul_y_o     = mul_y_q;
    assign res_valid_o = res_valid_q;
    assign res_data_o  = res_data_q;

    // operand storage, written only when not full
    always_ff @(posedge clk_in) begin
        if (push) begin
            mem_x[wr_ptr_q] <= in_x_i;
            mem_y[wr_ptr_q] <= in_y_i;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            unique case ({push, pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

`ifdef MULT_ISSUE_TIMEOUT_EN
    logic [3:0] wait_cnt_q;
    logic       err_q;

    // fires on the 15th WAIT cycle without a product
    assign timeout = (state_q == WAIT) && !mul_ready_i
                     && (wait_cnt_q == 4'd14);
    assign err_o   = err_q;

    // WAIT-cycle counter, cleared on entry to WAIT
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wait_cnt_q <= '0;
        end else if (state_q == ISSUE) begin
            wait_cnt_q <= '0;
        end else if (state_q == WAIT) begin
            wait_cnt_q <= wait_cnt_q + 4'd1;
        end
    end

    // sticky timeout flag
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            err_q <= 1'b0;
        end else if (timeout) begin
            err_q <= 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
    assign err_o   = 1'b0;
`endif

    // state register
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (issue_go) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT: begin
                if (mul_ready_i)  state_d = IDLE;
                else if (timeout) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // issue registers: start pulse and operands latched from the head
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            mul_start_q <= 1'b0;
            mul_x_q     <= '0;
            mul_y_q     <= '0;
        end else begin
            mul_start_q <= issue_go;
            if (issue_go) begin
                mul_x_q <= mem_x[rd_ptr_q];
                mul_y_q <= mem_y[rd_ptr_q];
            end
        end
    end

    // result capture and consumer handshake
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
        end else if ((state_q == WAIT) && mul_ready_i) begin
            res_valid_q <= 1'b1;
            res_data_q  <= mul_product_i;
        end else if (res_valid_q && res_ready_i) begin
            res_valid_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mult_issue_queue.sv
// Self-checking bench for mult_issue_queue: transaction-level model,
// directed scenarios, then randomized traffic with a multiplier responder.
module tb_mult_issue_queue;

    localparam int W     = 4;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic          in_valid_i;
    logic [W-1:0]  in_x_i, in_y_i;
    logic          in_ready_o;
    logic [W-1:0]  mul_x_o, mul_y_o;
    logic          mul_start_o;
    logic [W-1:0]  mul_product_i;
    logic          mul_ready_i;
    logic          res_valid_o;
    logic [W-1:0]  res_data_o;
    logic          res_ready_i;
    logic          err_o;
    logic [LW-1:0] level_o;

    always #5 clk_in = ~clk_in;

    mult_issue_queue #(.W(W), .DEPTH(DEPTH)) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .in_valid_i    (in_valid_i),
        .in_x_i        (in_x_i),
        .in_y_i        (in_y_i),
        .in_ready_o    (in_ready_o),
        .mul_x_o       (mul_x_o),
        .mul_y_o       (mul_y_o),
        .mul_start_o   (mul_start_o),
        .mul_product_i (mul_product_i),
        .mul_ready_i   (mul_ready_i),
        .res_valid_o   (res_valid_o),
        .res_data_o    (res_data_o),
        .res_ready_i   (res_ready_i),
        .err_o         (err_o),
        .level_o       (level_o)
    );

    int vectors     = 0;
    int miscompares = 0;

    // model: queued pairs plus the in-flight operation and result slot
    logic [2*W-1:0] mq[$];
    bit             m_start, m_busy, m_resv, m_err;
    logic [W-1:0]   m_x, m_y, m_resd;
    int             m_wcnt;

    // multiplier responder and issue log
    bit             rsp_pend;
    int             rsp_dly;
    logic [W-1:0]   rsp_px, rsp_py;
    logic [2*W-1:0] issued[$];

    task automatic chk(string nm, int act, int exp);
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step(bit rst, bit iv, logic [W-1:0] x, logic [W-1:0] y,
                              bit mr, logic [W-1:0] mp, bit rr);
        bit do_push;
        bit resv_pre;
        int pre;
        if (rst) begin
            mq.delete();
            m_start = 0; m_busy = 0; m_resv = 0; m_err = 0;
            m_x = '0; m_y = '0; m_resd = '0; m_wcnt = 0;
            return;
        end
        pre      = mq.size();
        resv_pre = m_resv;
        do_push  = iv && (pre < DEPTH);
        if (m_resv && rr) m_resv = 0;
        if (m_start) begin
            m_start = 0;
            void'(mq.pop_front());
            m_wcnt = 0;
        end else if (m_busy) begin
            if (mr) begin
                m_resv = 1;
                m_resd = mp;
                m_busy = 0;
            end
`ifdef MULT_ISSUE_TIMEOUT_EN
            else begin
                m_wcnt++;
                if (m_wcnt == 15) begin
                    m_err  = 1;
                    m_busy = 0;
                end
            end
`endif
        end else if (pre > 0 && !resv_pre) begin
            m_start = 1;
            m_busy  = 1;
            {m_x, m_y} = mq[0];
        end
        if (do_push) mq.push_back({x, y});
    endtask

    task automatic cyc(bit rst, bit iv, logic [W-1:0] x, logic [W-1:0] y,
                       bit mr, logic [W-1:0] mp, bit rr);
        rst_in        = rst;
        in_valid_i    = iv;
        in_x_i        = x;
        in_y_i        = y;
        mul_ready_i   = mr;
        mul_product_i = mp;
        res_ready_i   = rr;
        model_step(rst, iv, x, y, mr, mp, rr);
        @(posedge clk_in);
        #1;
        vectors++;
        chk("in_ready",  int'(in_ready_o),  int'(mq.size() < DEPTH));
        chk("level",     int'(level_o),     mq.size());
        chk("mul_start", int'(mul_start_o), int'(m_start));
        chk("mul_x",     int'(mul_x_o),     int'(m_x));
        chk("mul_y",     int'(mul_y_o),     int'(m_y));
        chk("res_valid", int'(res_valid_o), int'(m_resv));
        chk("res_data",  int'(res_data_o),  int'(m_resd));
        chk("err",       int'(err_o),       int'(m_err));
        if (mul_start_o) issued.push_back({mul_x_o, mul_y_o});
    endtask

    task automatic idle(bit rr);
        cyc(0, 0, '0, '0, 0, '0, rr);
    endtask

    // one cycle with the responder answering after a random delay
    task automatic rcyc(bit rst, bit iv, logic [W-1:0] x, logic [W-1:0] y,
                        bit rr, int maxdly, bit spur);
        bit             mr;
        logic [W-1:0]   mp;
        logic [2*W-1:0] p;
        if (m_busy && !m_start && !rsp_pend) begin
            rsp_pend = 1;
            rsp_dly  = $urandom_range(maxdly, 0);
            rsp_px   = m_x;
            rsp_py   = m_y;
        end
        mr = 0;
        mp = W'($urandom);
        if (rsp_pend) begin
            if (rsp_dly == 0) begin
                p        = rsp_px * rsp_py;
                mr       = 1;
                mp       = p[W-1:0];
                rsp_pend = 0;
            end else begin
                rsp_dly--;
            end
        end else if (spur && ($urandom_range(9, 0) == 0)) begin
            mr = 1;
        end
        cyc(rst, iv, x, y, mr, mp, rr);
        if (rst) rsp_pend = 0;
    endtask

    task automatic drain(int maxc);
        int n = 0;
        while ((mq.size() > 0 || m_busy || m_resv) && n < maxc) begin
            rcyc(0, 0, '0, '0, 1, 2, 0);
            n++;
        end
        chk("drain_done", int'(mq.size() > 0 || m_busy || m_resv), 0);
    endtask

    initial begin
        logic [2*W-1:0] exp4[4];
        logic [2*W-1:0] exp3[3];
        int             n;
        rst_in = 1; in_valid_i = 0; in_x_i = '0; in_y_i = '0;
        mul_ready_i = 0; mul_product_i = '0; res_ready_i = 0;
        rsp_pend = 0; rsp_dly = 0; rsp_px = '0; rsp_py = '0;
        model_step(1, 0, '0, '0, 0, '0, 0);

        // reset state
        cyc(1, 0, '0, '0, 0, '0, 0);
        cyc(1, 0, '0, '0, 0, '0, 0);
        chk("rst_level", int'(level_o), 0);
        chk("rst_ready", int'(in_ready_o), 1);
        chk("rst_resv", int'(res_valid_o), 0);
        chk("rst_start", int'(mul_start_o), 0);

        // single op (3,2), product 6 after 5 cycles
        cyc(0, 1, 4'd3, 4'd2, 0, '0, 0);
        chk("push1_level", int'(level_o), 1);
        idle(0);
        chk("lat2_start", int'(mul_start_o), 1);
        chk("lat2_x", int'(mul_x_o), 3);
        chk("lat2_y", int'(mul_y_o), 2);
        for (int i = 0; i < 4; i++) idle(0);
        chk("one_pulse", int'(mul_start_o), 0);
        chk("hold_x", int'(mul_x_o), 3);
        cyc(0, 0, '0, '0, 1, 4'd6, 0);
        chk("res6_valid", int'(res_valid_o), 1);
        chk("res6_data", int'(res_data_o), 6);
        idle(0);
        chk("res6_hold", int'(res_data_o), 6);
        idle(1);
        chk("res6_clear", int'(res_valid_o), 0);

        // fill while the result is held; 5th push refused
        cyc(0, 1, 4'd1, 4'd1, 0, '0, 0);
        idle(0);
        idle(0);
        cyc(0, 0, '0, '0, 1, 4'd1, 0);
        chk("held_resv", int'(res_valid_o), 1);
        issued.delete();
        exp4[0] = {4'd2, 4'd3};
        exp4[1] = {4'd3, 4'd3};
        exp4[2] = {4'd1, 4'd5};
        exp4[3] = {4'd2, 4'd2};
        for (int i = 0; i < 4; i++)
            cyc(0, 1, exp4[i][2*W-1:W], exp4[i][W-1:0], 0, '0, 0);
        chk("full_level", int'(level_o), 4);
        chk("full_ready", int'(in_ready_o), 0);
        cyc(0, 1, 4'd7, 4'd7, 0, '0, 0);
        chk("full_refuse", int'(level_o), 4);
        for (int i = 0; i < 3; i++) idle(0);
        chk("no_issue_held", issued.size(), 0);
        drain(80);
        chk("order4_cnt", issued.size(), 4);
        for (int i = 0; i < 4 && i < issued.size(); i++)
            chk("order4", int'(issued[i]), int'(exp4[i]));

        // push and pop in the same cycle at level 2
        cyc(0, 1, 4'd1, 4'd2, 0, '0, 0);
        n = 0;
        while (!m_resv && n < 30) begin
            rcyc(0, 0, '0, '0, 0, 2, 0);
            n++;
        end
        chk("held2_resv", int'(res_valid_o), 1);
        issued.delete();
        exp3[0] = {4'd2, 4'd2};
        exp3[1] = {4'd3, 4'd1};
        exp3[2] = {4'd1, 4'd3};
        cyc(0, 1, 4'd2, 4'd2, 0, '0, 0);
        cyc(0, 1, 4'd3, 4'd1, 0, '0, 0);
        chk("lvl2", int'(level_o), 2);
        idle(1);
        idle(0);
        chk("lvl2_issue", int'(mul_start_o), 1);
        cyc(0, 1, 4'd1, 4'd3, 0, '0, 0);
        chk("pushpop_lvl", int'(level_o), 2);
        drain(80);
        chk("order3_cnt", issued.size(), 3);
        for (int i = 0; i < 3 && i < issued.size(); i++)
            chk("order3", int'(issued[i]), int'(exp3[i]));

        // reset during WAIT discards the op
        cyc(0, 1, 4'd2, 4'd2, 0, '0, 0);
        idle(0);
        idle(0);
        cyc(1, 0, '0, '0, 0, '0, 0);
        cyc(0, 0, '0, '0, 1, 4'd9, 0);
        chk("rstw_resv", int'(res_valid_o), 0);
        chk("rstw_level", int'(level_o), 0);
        idle(0);
        chk("rstw_resv2", int'(res_valid_o), 0);

`ifdef MULT_ISSUE_TIMEOUT_EN
        // watchdog: err after 15 WAIT cycles, then next pair issues
        cyc(0, 1, 4'd3, 4'd3, 0, '0, 0);
        cyc(0, 1, 4'd2, 4'd5, 0, '0, 0);
        for (int i = 0; i < 15; i++) idle(0);
        chk("to_err_early", int'(err_o), 0);
        idle(0);
        chk("to_err", int'(err_o), 1);
        chk("to_resv", int'(res_valid_o), 0);
        idle(0);
        chk("to_next_start", int'(mul_start_o), 1);
        chk("to_next_x", int'(mul_x_o), 2);
        chk("to_next_y", int'(mul_y_o), 5);
        cyc(1, 0, '0, '0, 0, '0, 0);
        chk("to_err_rst", int'(err_o), 0);
`endif

        // randomized traffic
        rsp_pend = 0;
        for (int i = 0; i < 2500; i++) begin
`ifdef MULT_ISSUE_TIMEOUT_EN
            rcyc($urandom_range(299, 0) == 0, $urandom_range(1, 0) == 1,
                 W'($urandom), W'($urandom), $urandom_range(9, 0) < 6, 20, 1);
`else
            rcyc($urandom_range(299, 0) == 0, $urandom_range(1, 0) == 1,
                 W'($urandom), W'($urandom), $urandom_range(9, 0) < 6, 6, 1);
`endif
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mult_issue_queue.md
MULT_ISSUE_QUEUE -- requirements
Module: mult_issue_queue

Interface
REQ-001 The block SHALL have parameter W, default 4, giving the operand and product width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 4, giving the operand FIFO entry count (power of two, at least 2).
REQ-003 clk_in  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_in  input  1  reset, synchronous and active-high.
REQ-005 in_valid_i  input  1  operand pair offered.
REQ-006 in_x_i, in_y_i  input  W each  operand pair.
REQ-007 in_ready_o  output  1  FIFO can accept; equals not-full.
REQ-008 mul_x_o, mul_y_o  output  W each  operands driven to the downstream sequential multiplier.
REQ-009 mul_start_o  output  1  one-cycle start pulse to the multiplier.
REQ-010 mul_product_i  input  W  multiplier result.
REQ-011 mul_ready_i  input  1  multiplier result valid.
REQ-012 res_valid_o, res_data_o  output  1, W  captured result and its valid flag.
REQ-013 res_ready_i  input  1  consumer accepts the result.
REQ-014 err_o  output  1  sticky timeout flag.
REQ-015 level_o  output  clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-016 A push SHALL occur on a rising edge with in_valid_i=1 and in_ready_o=1; the FIFO SHALL never be written while full, even if a pop happens in the same cycle.
REQ-017 On a simultaneous push and pop, level_o SHALL stay unchanged and ordering SHALL stay FIFO.
REQ-018 Read and write pointers SHALL wrap modulo DEPTH.
REQ-019 The FSM SHALL have states IDLE, ISSUE and WAIT.
REQ-020 The FSM SHALL move from IDLE to ISSUE when the FIFO is non-empty and res_valid_o=0; otherwise it SHALL remain in IDLE.
REQ-021 In ISSUE, mul_start_o SHALL be 1 for exactly one cycle with mul_x_o/mul_y_o equal to the FIFO head; the head SHALL pop at the end of that cycle; the next state SHALL be WAIT.
REQ-022 mul_x_o/mul_y_o SHALL hold the issued operands through WAIT.
REQ-023 In WAIT with mul_ready_i=1, the block SHALL load res_data_o with mul_product_i, set res_valid_o=1, and return to IDLE.
REQ-024 res_valid_o SHALL clear on the edge where res_valid_o=1 and res_ready_i=1; res_data_o SHALL hold while res_valid_o=1.
REQ-025 Minimum latency from a push into an empty FIFO to mul_start_o SHALL be 2 cycles (push edge, then IDLE->ISSUE edge).
REQ-026 mul_ready_i SHALL be ignored in IDLE and ISSUE.
REQ-027 Only one operation SHALL be in flight at any time.

Reset
REQ-028 While rst_in=1 at an edge, the block SHALL clear all state: FSM=IDLE, pointers and level_o=0, mul_start_o=0, mul_x_o/mul_y_o=0, res_valid_o=0, res_data_o=0, err_o=0, and the timeout counter=0.
REQ-029 After reset, in_ready_o SHALL be 1.
REQ-030 A reset during WAIT SHALL discard the in-flight operation, and any later mul_ready_i for it SHALL be ignored.

Configuration
REQ-031 With macro MULT_ISSUE_TIMEOUT_EN defined, a 4-bit counter SHALL increment every WAIT cycle and clear on entry to WAIT.
REQ-032 With the macro defined, if the counter reaches 15 without mul_ready_i, the block SHALL set err_o=1 (sticky until reset), drop the operation without setting res_valid_o, and return to IDLE.
REQ-033 Without the macro, WAIT SHALL persist until mul_ready_i, err_o SHALL be tied to 0, and no counter logic SHALL exist.

Verification
REQ-034 Reset, then push (3,2); model the multiplier returning 6 after 5 cycles -> mul_start_o pulses once with x=3, y=2; res_valid_o=1 with res_data_o=6; it clears on res_ready_i.
REQ-035 Push 4 pairs back-to-back with the multiplier stalled -> level_o=4 and in_ready_o=0; a 5th in_valid_i is not accepted.
REQ-036 Hold res_ready_i=0 after the first result, with 2 pairs queued -> no further mul_start_o until res_ready_i=1.
REQ-037 Push and pop in the same cycle at level_o=2 -> level_o remains 2 and results return in push order.
REQ-038 Assert rst_in during WAIT, then drive mul_ready_i=1 with product 9 -> res_valid_o stays 0 and level_o=0.
REQ-039 With MULT_ISSUE_TIMEOUT_EN defined, hold mul_ready_i=0 -> err_o=1 15 cycles after entering WAIT, and the next queued pair issues.
